anita3_trig_pattern_buffer: RTL
===============================

Name: anita3_trig_pattern_buffer

Overview:
Downstream of the simple RF trigger. Captures the phi-sector hit pattern and RF count on each issued trigger and tags it with an event number. Stores these records in a small first-word-fall-through FIFO for the readout/TURFIO side, which drains it with a valid/ready handshake. Reports buffer-full as a busy/deadtime indication and counts triggers lost to overflow.

Parameters:
NUM_PHI, 16, phi sectors per polarization; pattern width is 2*NUM_PHI (H in upper half, V in lower half).
COUNT_BITS, 8, width of the incoming RF trigger count.
DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4 records).
EVNUM_BITS, 16, width of the event number and lost-trigger counter.

Ports:
clk250_i  in  1  250 MHz trigger clock; all logic on its rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
trig_i  in  1  issued RF trigger from the trigger stage.
phi_i  in  2*NUM_PHI  latched phi pattern {H,V}, stable while trig_i is high.
count_i  in  COUNT_BITS  RF trigger count accompanying trig_i.
disable_i  in  1  run disable; when high, triggers are ignored entirely.
rd_valid_o  out  1  head record available.
rd_ready_i  in  1  consumer accepts the head record.
rd_phi_o  out  2*NUM_PHI  head record pattern.
rd_count_o  out  COUNT_BITS  head record RF count.
rd_evnum_o  out  EVNUM_BITS  head record event number.
busy_o  out  1  FIFO full (deadtime indication).
fill_o  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
lost_o  out  EVNUM_BITS  triggers dropped because the FIFO was full; saturating.

Behaviour:
- Reset (async assert, sync release): FIFO empty.
  - rd_valid_o=0, busy_o=0, fill_o=0, lost_o=0.
  - Event counter=0; rd_phi_o, rd_count_o, rd_evnum_o=0.
  - Trigger edge-detect register=0.
  - Reset asserted mid-operation flushes all stored records immediately.
- Trigger qualification:
  - trig_d registers trig_i each cycle.
  - A qualified edge is trig_i && !trig_d && !disable_i.
  - A multi-cycle trig_i yields one edge.
  - disable_i high during an edge: no capture, event counter unchanged, lost_o unchanged.
- Capture: on a qualified edge in cycle N, record {phi_i, count_i, evcnt} is formed from values sampled at edge N.
  - Event counter evcnt increments (wraps modulo 2^EVNUM_BITS) on every qualified edge, accepted or dropped. Dropped events therefore appear as gaps in rd_evnum_o.
  - The first record after reset carries evnum 0.
- Push acceptance: let pop = rd_valid_o && rd_ready_i in the same cycle.
  - Push is accepted if fill < 2^DEPTH_LOG2, or if pop is true (full with simultaneous pop accepts the push).
  - Otherwise the record is discarded and lost_o increments, saturating at all-ones.
- Pop: on pop, the head advances.
  - rd_ready_i while rd_valid_o=0 has no effect.
  - Output fields hold their value while rd_valid_o=1 and rd_ready_i=0.
- Latency: with the FIFO empty, a qualified edge sampled at clock edge N gives rd_valid_o=1 and valid fields after edge N+1 (one-cycle latency). No bypass of the storage.
- Occupancy:
  - fill_o is +1 on push-only, -1 on pop-only, unchanged on push+pop or on neither.
  - busy_o = (fill_o == 2^DEPTH_LOG2), registered consistently with fill_o.
  - rd_valid_o = (fill_o != 0).
- Pointers: read/write pointers are DEPTH_LOG2 bits wide and wrap naturally. Storage may be register array or distributed RAM; outputs come from the head entry.
- Ordering: strict FIFO; records exit in capture order.

Test Plan:
- Reset, then trig_i high for 3 cycles with phi_i=0x0003_8000, count_i=0x05, rd_ready_i=0 -> one record; after 1 cycle rd_valid_o=1, rd_phi_o=0x00038000, rd_count_o=5, rd_evnum_o=0, fill_o=1.
- 6 single-cycle trig_i pulses spaced 4 cycles apart, rd_ready_i=0, depth 4 -> fill_o=4, busy_o=1, lost_o=2. Draining then yields evnum 0,1,2,3 in order; a following trigger yields evnum 6.
- FIFO full, a qualified edge in the same cycle as rd_ready_i=1 -> push accepted, lost_o unchanged, fill_o stays 4, new tail carries the next evnum.
- disable_i=1 during 3 triggers, then disable_i=0 and 1 trigger -> only one record, evnum 0, lost_o=0.
- rd_ready_i held 1 with a trigger every 2 cycles for 100 triggers -> fill_o never exceeds 1, lost_o=0, evnums 0..99 contiguous.
- FIFO holding 3 records, rst_n_i pulsed low asynchronously mid-cycle -> rd_valid_o=0 and fill_o=0 immediately. The next trigger gets evnum 0.

Source files
------------

// File: rtl/anita3_trig_pattern_buffer.sv
// ANITA-3 trigger pattern buffer: captures {phi pattern, RF count, event number}
// on each qualified trigger edge into a small FWFT FIFO drained by valid/ready.
module anita3_trig_pattern_buffer #(
    parameter int unsigned NUM_PHI    = 16,
    parameter int unsigned COUNT_BITS = 8,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned EVNUM_BITS = 16
) (
    input  logic                    clk250_i,
    input  logic                    rst_n_i,
    input  logic                    trig_i,
    input  logic [2*NUM_PHI-1:0]    phi_i,
    input  logic [COUNT_BITS-1:0]   count_i,
    input  logic                    disable_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [2*NUM_PHI-1:0]    rd_phi_o,
    output logic [COUNT_BITS-1:0]   rd_count_o,
    output logic [EVNUM_BITS-1:0]   rd_evnum_o,
    output logic                    busy_o,
    output logic [DEPTH_LOG2:0]     fill_o,
    output logic [EVNUM_BITS-1:0]   lost_o
);

    localparam int unsigned PHI_W  = 2 * NUM_PHI;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned FILL_W = DEPTH_LOG2 + 1;

    logic                  trig_q;
    logic [EVNUM_BITS-1:0] evcnt_q, evcnt_d;
    logic [EVNUM_BITS-1:0] lost_q, lost_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  valid_q, busy_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;

    logic [PHI_W-1:0]      phi_mem_q [DEPTH];
    logic [COUNT_BITS-1:0] cnt_mem_q [DEPTH];
    logic [EVNUM_BITS-1:0] ev_mem_q  [DEPTH];

    logic edge_c, pop_c, push_c, drop_c;

    // Qualify the trigger edge and decide push/pop/drop for this cycle.
    always_comb begin
        edge_c = trig_i & ~trig_q & ~disable_i;
        pop_c  = valid_q & rd_ready_i;
        // A full FIFO still accepts the push when the head leaves in the same cycle.
        push_c = edge_c & (~busy_q | pop_c);
        drop_c = edge_c & ~push_c;
    end

    // Next-state for counters, pointers and occupancy.
    always_comb begin
        evcnt_d  = evcnt_q;
        lost_d   = lost_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (edge_c) evcnt_d = evcnt_q + EVNUM_BITS'(1);
        if (drop_c && (lost_q != '1)) lost_d = lost_q + EVNUM_BITS'(1);
        if (push_c) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({push_c, pop_c})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Control and status registers; valid/busy are registered alongside fill.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_q   <= 1'b0;
            evcnt_q  <= '0;
            lost_q   <= '0;
            fill_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            trig_q   <= trig_i;
            evcnt_q  <= evcnt_d;
            lost_q   <= lost_d;
            fill_q   <= fill_d;
            valid_q  <= (fill_d != '0);
            busy_q   <= (fill_d == FILL_W'(DEPTH));
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Record storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                phi_mem_q[i] <= '0;
                cnt_mem_q[i] <= '0;
                ev_mem_q[i]  <= '0;
            end
        end else if (push_c) begin
            phi_mem_q[wr_ptr_q] <= phi_i;
            cnt_mem_q[wr_ptr_q] <= count_i;
            ev_mem_q[wr_ptr_q]  <= evcnt_q;
        end
    end

    assign rd_valid_o = valid_q;
    assign busy_o     = busy_q;
    assign fill_o     = fill_q;
    assign lost_o     = lost_q;
    assign rd_phi_o   = phi_mem_q[rd_ptr_q];
    assign rd_count_o = cnt_mem_q[rd_ptr_q];
    assign rd_evnum_o = ev_mem_q[rd_ptr_q];

endmodule
